// File: rtl/regfile_valid_tracker_if.sv
// Bundle of rename-side inputs and valid-bit outputs for the register valid tracker.
// The master side (rename/ROB control) drives inputs; the tracker sits on the slave side.
interface regfile_valid_tracker_if #(
    parameter int AREGS  = 128,
    parameter int QSLOTS = 3,
    parameter int CSLOTS = 2,
    parameter int RBIT   = 6,
    parameter int RIDW   = 5
) ();

    logic                            branchmiss;
    logic [AREGS-1:0]                miss_live;
    logic [QSLOTS-1:0]               slotvd;
    logic [QSLOTS-1:0]               queuedOn;
    logic [QSLOTS-1:0]               slot_rfw;
    logic [QSLOTS-1:0][RBIT:0]       Rd;
    logic [QSLOTS-1:0][RBIT:0]       Rd2;
    logic [CSLOTS-1:0]               commit_v;
    logic [CSLOTS-1:0][RBIT:0]       commit_tgt;
    logic [CSLOTS-1:0][RIDW-1:0]     commit_rid;
    logic [AREGS-1:0][RIDW:0]        rf_source;
    logic [AREGS-1:0]                rf_v;
    logic [7:0]                      pend_cnt;

    modport master (
        output branchmiss, miss_live,
        output slotvd, queuedOn, slot_rfw, Rd, Rd2,
        output commit_v, commit_tgt, commit_rid, rf_source,
        input  rf_v, pend_cnt
    );

    modport slave (
        input  branchmiss, miss_live,
        input  slotvd, queuedOn, slot_rfw, Rd, Rd2,
        input  commit_v, commit_tgt, commit_rid, rf_source,
        output rf_v, pend_cnt
    );

endinterface

// File: rtl/regfile_valid_tracker.sv
// Per-register valid bits: enqueued writers clear, matching ROB commits set, branch miss rebuilds.
// Registers 0 and 64 are hardwired valid; pend_cnt counts the pending (invalid) registers.
module regfile_valid_tracker #(
    parameter int AREGS  = 128,
    parameter int QSLOTS = 3,
    parameter int CSLOTS = 2,
    parameter int RBIT   = 6,
    parameter int RIDW   = 5
) (
    input logic                    clk,
    input logic                    rst,
    regfile_valid_tracker_if.slave bus
);

    logic [QSLOTS-1:0] accepted;
    logic [AREGS-1:0]  clr_mask;
    logic [AREGS-1:0]  set_mask;
    logic [AREGS-1:0]  rf_next;
    logic [7:0]        pend_next;
    logic [AREGS-1:0]  rf_v_q;
    logic [7:0]        pend_q;
    logic [AREGS-1:0]  src_flags;
    logic              unused_src_flags;

    function automatic logic in_range(input logic [RBIT:0] r);
        return int'(r) < AREGS;
    endfunction

    // A valid slot that is not queued blocks every later slot in the same cycle.
    always_comb begin : accept_logic
        logic lower_ok;
        lower_ok = 1'b1;
        accepted = '0;
        for (int k = 0; k < QSLOTS; k++) begin
            accepted[k] = lower_ok & bus.slotvd[k] & bus.queuedOn[k];
            if (bus.slotvd[k] && !accepted[k]) begin
                lower_ok = 1'b0;
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < QSLOTS; k++) begin
            if (accepted[k] && bus.slot_rfw[k]) begin
                if (in_range(bus.Rd[k])) begin
                    clr_mask[bus.Rd[k]] = 1'b1;
                end
                if (bus.Rd2[k] != '0 && in_range(bus.Rd2[k])) begin
                    clr_mask[bus.Rd2[k]] = 1'b1;
                end
            end
        end
    end

    // Only the commit whose ROB id still owns the register may revalidate it.
    always_comb begin
        set_mask = '0;
        for (int c = 0; c < CSLOTS; c++) begin
            if (bus.commit_v[c] && in_range(bus.commit_tgt[c])) begin
                if (bus.rf_source[bus.commit_tgt[c]][RIDW-1:0] == bus.commit_rid[c]) begin
                    set_mask[bus.commit_tgt[c]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (bus.branchmiss) begin
            rf_next = ~bus.miss_live;
        end else begin
            rf_next = (rf_v_q | set_mask) & ~clr_mask;
        end
        rf_next[0] = 1'b1;
        if (AREGS > 64) begin
            rf_next[64] = 1'b1;
        end
    end

    always_comb begin
        pend_next = '0;
        for (int i = 0; i < AREGS; i++) begin
            pend_next = pend_next + {7'b0, ~rf_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_v_q <= '1;
            pend_q <= '0;
        end else begin
            rf_v_q <= rf_next;
            pend_q <= pend_next;
        end
    end

    // The Rd2 flag bit of the source table has no bearing on validity.
    always_comb begin
        for (int i = 0; i < AREGS; i++) begin
            src_flags[i] = bus.rf_source[i][RIDW];
        end
    end

    assign unused_src_flags = ^src_flags;

    assign bus.rf_v     = rf_v_q;
    assign bus.pend_cnt = pend_q;

endmodule

// File: tb/tb_regfile_valid_tracker.sv
// Directed bench for regfile_valid_tracker: each step queues its expected rf_v/pend_cnt,
// and the result one edge later is popped from the scoreboard and compared.
module tb_regfile_valid_tracker;

    localparam int AREGS  = 128;
    localparam int QSLOTS = 3;
    localparam int CSLOTS = 2;
    localparam int RBIT   = 6;
    localparam int RIDW   = 5;

    logic clk;
    logic rst;

    regfile_valid_tracker_if #(
        .AREGS(AREGS), .QSLOTS(QSLOTS), .CSLOTS(CSLOTS), .RBIT(RBIT), .RIDW(RIDW)
    ) bus ();

    regfile_valid_tracker #(
        .AREGS(AREGS), .QSLOTS(QSLOTS), .CSLOTS(CSLOTS), .RBIT(RBIT), .RIDW(RIDW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    string            tag_q[$];
    logic [AREGS-1:0] v_q[$];
    logic [7:0]       cnt_q[$];

    logic [AREGS-1:0] mv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearInputs();
        bus.branchmiss = 1'b0;
        bus.miss_live  = '0;
        bus.slotvd     = '0;
        bus.queuedOn   = '0;
        bus.slot_rfw   = '0;
        bus.Rd         = '0;
        bus.Rd2        = '0;
        bus.commit_v   = '0;
        bus.commit_tgt = '0;
        bus.commit_rid = '0;
    endtask

    task automatic checkOutput();
        string            tag;
        logic [AREGS-1:0] ev;
        logic [7:0]       ec;
        tag = tag_q.pop_front();
        ev  = v_q.pop_front();
        ec  = cnt_q.pop_front();
        checks++;
        assert (bus.rf_v === ev) else begin
            errors++;
            $error("[TB] FAIL %s rf_v observed %h expected %h", tag, bus.rf_v, ev);
        end
        checks++;
        assert (bus.pend_cnt === ec) else begin
            errors++;
            $error("[TB] FAIL %s pend_cnt observed %0d expected %0d", tag, bus.pend_cnt, ec);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [AREGS-1:0] ev, input logic [7:0] ec);
        tag_q.push_back(tag);
        v_q.push_back(ev);
        cnt_q.push_back(ec);
        @(posedge clk);
        #1;
        checkOutput();
        clearInputs();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        bus.rf_source = '0;
        #1;

        mv = '1;
        applyStimulus("reset", mv, 8'd0);

        bus.slotvd = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001;
        bus.Rd[0] = 7'd5;
        mv[5] = 1'b0;
        applyStimulus("enq_r5", mv, 8'd1);

        bus.slotvd = 3'b111; bus.queuedOn = 3'b101; bus.slot_rfw = 3'b111;
        bus.Rd[0] = 7'd7; bus.Rd[1] = 7'd8; bus.Rd[2] = 7'd9;
        mv[7] = 1'b0;
        applyStimulus("in_order_accept", mv, 8'd2);

        bus.rf_source[5] = 6'h03;
        bus.commit_v = 2'b01; bus.commit_tgt[0] = 7'd5; bus.commit_rid[0] = 5'd4;
        applyStimulus("stale_commit", mv, 8'd2);

        bus.commit_v = 2'b01; bus.commit_tgt[0] = 7'd5; bus.commit_rid[0] = 5'd3;
        mv[5] = 1'b1;
        applyStimulus("commit_r5", mv, 8'd1);

        bus.rf_source[7] = 6'h21;
        bus.commit_v = 2'b10; bus.commit_tgt[1] = 7'd7; bus.commit_rid[1] = 5'd1;
        mv[7] = 1'b1;
        applyStimulus("commit_port1_flag", mv, 8'd0);

        bus.slotvd = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001;
        bus.Rd[0] = 7'd10;
        mv[10] = 1'b0;
        applyStimulus("enq_r10", mv, 8'd1);

        bus.rf_source[10] = 6'h02;
        bus.slotvd = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001;
        bus.Rd[0] = 7'd10;
        bus.commit_v = 2'b01; bus.commit_tgt[0] = 7'd10; bus.commit_rid[0] = 5'd2;
        applyStimulus("enq_beats_commit", mv, 8'd1);

        bus.commit_v = 2'b11;
        bus.commit_tgt[0] = 7'd10; bus.commit_rid[0] = 5'd9;
        bus.commit_tgt[1] = 7'd10; bus.commit_rid[1] = 5'd2;
        mv[10] = 1'b1;
        applyStimulus("dual_commit_one_match", mv, 8'd0);

        bus.slotvd = 3'b111; bus.queuedOn = 3'b111; bus.slot_rfw = 3'b111;
        bus.Rd[0] = 7'd3; bus.Rd[1] = 7'd4; bus.Rd[2] = 7'd6;
        mv[3] = 1'b0; mv[4] = 1'b0; mv[6] = 1'b0;
        applyStimulus("enq_3_4_6", mv, 8'd3);

        bus.branchmiss = 1'b1;
        bus.miss_live = '0; bus.miss_live[4] = 1'b1;
        bus.slotvd = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001;
        bus.Rd[0] = 7'd20;
        mv = '1; mv[4] = 1'b0;
        applyStimulus("branchmiss_rebuild", mv, 8'd1);

        bus.slotvd = 3'b111; bus.queuedOn = 3'b111; bus.slot_rfw = 3'b011;
        bus.Rd[0] = 7'd11; bus.Rd2[0] = 7'd12;
        bus.Rd[1] = 7'd13; bus.Rd2[1] = 7'd0;
        bus.Rd[2] = 7'd14; bus.Rd2[2] = 7'd15;
        mv[11] = 1'b0; mv[12] = 1'b0; mv[13] = 1'b0;
        applyStimulus("rd2_and_rfw", mv, 8'd4);

        bus.branchmiss = 1'b1;
        bus.miss_live = '0;
        bus.miss_live[0] = 1'b1; bus.miss_live[64] = 1'b1; bus.miss_live[30] = 1'b1;
        mv = '1; mv[30] = 1'b0;
        applyStimulus("miss_hardwired", mv, 8'd1);

        bus.branchmiss = 1'b1;
        bus.miss_live = '0;
        mv = '1;
        applyStimulus("miss_clear_all", mv, 8'd0);

        bus.slotvd = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001;
        bus.Rd[0] = 7'd0; bus.Rd2[0] = 7'd64;
        applyStimulus("enq_r0_r64", mv, 8'd0);

        bus.branchmiss = 1'b1;
        bus.miss_live = '1;
        mv = '0; mv[0] = 1'b1; mv[64] = 1'b1;
        applyStimulus("max_pending", mv, 8'd126);

        rst = 1'b1;
        bus.branchmiss = 1'b1;
        bus.miss_live = '1;
        bus.slotvd = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001;
        bus.Rd[0] = 7'd40;
        mv = '1;
        applyStimulus("reset_beats_miss", mv, 8'd0);

        applyStimulus("post_reset_idle", mv, 8'd0);

        checks++;
        assert (tag_q.size() === 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain observed %0d entries expected 0", tag_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
